// File: rtl/npc_pkg.sv
// Shared NPC front-end definitions: reset fetch PC and fetch FSM state encoding.
package npc_pkg;

    localparam logic [63:0] PC_ENTRY = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-memory req/gnt/rvalid bus plus the fetch-to-decode valid/ready handshake.
interface ifu_fetch_ctrl_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned INST_W = 32
) ();
    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [WIDTH-1:0]  inst_pc;
    logic              id_ready;

    // master = fetch controller side
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/ifu_redirect_sel.sv
// Combinational redirect priority: exception over trap-return over branch.
module ifu_redirect_sel #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_ex,
    input  logic [WIDTH-1:0] i_ex_entry,
    input  logic             i_ex_ret,
    input  logic [WIDTH-1:0] i_epc,
    input  logic             i_br_taken,
    input  logic [WIDTH-1:0] i_br_target,
    output logic             o_redirect,
    output logic [WIDTH-1:0] o_tgt
);
    always_comb begin
        o_redirect = i_ex | i_ex_ret | i_br_taken;
        if (i_ex) begin
            o_tgt = i_ex_entry;
        end else if (i_ex_ret) begin
            o_tgt = i_epc;
        end else begin
            o_tgt = i_br_target;
        end
    end
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one imem request in flight, drops stale
// responses after redirects and hands instructions to decode.
module ifu_fetch_ctrl #(
    parameter int unsigned     WIDTH    = 64,
    parameter int unsigned     INST_W   = 32,
    parameter logic [WIDTH-1:0] PC_ENTRY = WIDTH'(npc_pkg::PC_ENTRY)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ex,
    input  logic [WIDTH-1:0]   i_ex_entry,
    input  logic               i_ex_ret,
    input  logic [WIDTH-1:0]   i_epc,
    input  logic               i_br_taken,
    input  logic [WIDTH-1:0]   i_br_target,
    output logic [WIDTH-1:0]   o_pc,
    ifu_fetch_ctrl_if.master   bus
);
    import npc_pkg::*;

    logic             w_redirect;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_fpc_d;

    fetch_state_e      r_state;
    logic [WIDTH-1:0]  r_fpc;
    logic [WIDTH-1:0]  r_addr;
    logic              r_drop;
    logic              r_req;
    logic              r_inst_valid;
    logic [INST_W-1:0] r_inst;
    logic [WIDTH-1:0]  r_inst_pc;

    ifu_redirect_sel #(
        .WIDTH (WIDTH)
    ) u_redirect_sel (
        .i_ex        (i_ex),
        .i_ex_entry  (i_ex_entry),
        .i_ex_ret    (i_ex_ret),
        .i_epc       (i_epc),
        .i_br_taken  (i_br_taken),
        .i_br_target (i_br_target),
        .o_redirect  (w_redirect),
        .o_tgt       (w_tgt)
    );

    // Once drop is set fpc already holds the redirect target, so a late grant must not bump it.
    always_comb begin
        w_fpc_d = r_fpc;
        if (w_redirect) begin
            w_fpc_d = w_tgt;
        end else if (r_state == StReq && bus.imem_gnt && !r_drop) begin
            w_fpc_d = r_fpc + WIDTH'(4);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_fpc        <= PC_ENTRY;
            r_addr       <= PC_ENTRY;
            r_drop       <= 1'b0;
            r_req        <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_fpc <= w_fpc_d;
            unique case (r_state)
                StIdle: begin
                    r_state <= StReq;
                    r_req   <= 1'b1;
                    r_addr  <= w_fpc_d;
                end
                StReq: begin
                    if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                    if (bus.imem_gnt) begin
                        r_state <= StWait;
                        r_req   <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid) begin
                        if (r_drop || w_redirect) begin
                            r_drop  <= 1'b0;
                            r_state <= StReq;
                            r_req   <= 1'b1;
                            r_addr  <= w_fpc_d;
                        end else begin
                            r_inst       <= bus.imem_rdata;
                            r_inst_pc    <= r_addr;
                            r_inst_valid <= 1'b1;
                            r_state      <= StHold;
                        end
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                StHold: begin
                    if (w_redirect || bus.id_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= StReq;
                        r_req        <= 1'b1;
                        r_addr       <= w_fpc_d;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req   = r_req;
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign o_pc           = r_fpc;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a zero-wait imem responder that can hold a response.
module tb_ifu_fetch_ctrl;
    logic        clk;
    logic        rst;
    logic        ex;
    logic [63:0] ex_entry;
    logic        ex_ret;
    logic [63:0] epc;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] pc;

    logic        resp_en;
    logic        pend;
    logic [63:0] pend_addr;

    int n_checks;
    int n_fail;

    ifu_fetch_ctrl_if #(.WIDTH(64), .INST_W(32)) bus ();

    ifu_fetch_ctrl #(
        .WIDTH    (64),
        .INST_W   (32),
        .PC_ENTRY (64'h0000_0000_8000_0000)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ex        (ex),
        .i_ex_entry  (ex_entry),
        .i_ex_ret    (ex_ret),
        .i_epc       (epc),
        .i_br_taken  (br_taken),
        .i_br_target (br_target),
        .o_pc        (pc),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; a granted request is answered the following cycle unless responses are held.
    task automatic tick();
        logic        fire;
        logic [63:0] a;
        fire = bus.imem_req & bus.imem_gnt;
        a    = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        if (fire === 1'b1) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        if (pend && resp_en) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend_addr[31:0] ^ 32'h0000_0013;
            pend            = 1'b0;
        end
    endtask

    task automatic release_resp();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_addr[31:0] ^ 32'h0000_0013;
        pend            = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_a;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; ex = 1'b0; ex_ret = 1'b0; br_taken = 1'b0;
        ex_entry = '0; epc = '0; br_target = '0;
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
        resp_en = 1'b1; pend = 1'b0; pend_addr = '0;

        // Reset
        tick();
        tick();
        check_val("rst_req", {63'd0, bus.imem_req}, 64'd0);
        check_val("rst_valid", {63'd0, bus.inst_valid}, 64'd0);
        check_val("rst_pc", pc, 64'h8000_0000);
        check_val("rst_inst_pc", bus.inst_pc, 64'd0);
        rst = 1'b0;
        tick();
        check_val("boot_req", {63'd0, bus.imem_req}, 64'd1);
        check_val("boot_addr", bus.imem_addr, 64'h8000_0000);

        // Sequential fetch, one instruction per 3 cycles
        for (int k = 0; k < 3; k++) begin
            exp_a = 64'h8000_0000 + 64'(4 * k);
            check_val("seq_req", {63'd0, bus.imem_req}, 64'd1);
            check_val("seq_addr", bus.imem_addr, exp_a);
            tick();
            check_val("seq_wait_req", {63'd0, bus.imem_req}, 64'd0);
            check_val("seq_pc_inc", pc, exp_a + 64'd4);
            tick();
            check_val("seq_valid", {63'd0, bus.inst_valid}, 64'd1);
            check_val("seq_inst", {32'd0, bus.inst}, {32'd0, exp_a[31:0] ^ 32'h13});
            check_val("seq_inst_pc", bus.inst_pc, exp_a);
            if (k == 2) bus.id_ready = 1'b0;
            tick();
        end

        // Decode stall in HOLD
        for (int k = 0; k < 5; k++) begin
            check_val("stall_valid", {63'd0, bus.inst_valid}, 64'd1);
            check_val("stall_inst", {32'd0, bus.inst}, 64'h8000_001B);
            check_val("stall_inst_pc", bus.inst_pc, 64'h8000_0008);
            check_val("stall_req", {63'd0, bus.imem_req}, 64'd0);
            tick();
        end
        bus.id_ready = 1'b1;
        tick();
        check_val("unstall_req", {63'd0, bus.imem_req}, 64'd1);
        check_val("unstall_addr", bus.imem_addr, 64'h8000_000C);

        // Branch while waiting for a held response
        resp_en = 1'b0;
        tick();
        br_taken = 1'b1; br_target = 64'h8000_1000;
        tick();
        br_taken = 1'b0;
        check_val("br_pc", pc, 64'h8000_1000);
        check_val("br_wait_req", {63'd0, bus.imem_req}, 64'd0);
        release_resp();
        tick();
        resp_en = 1'b1;
        check_val("br_drop_valid", {63'd0, bus.inst_valid}, 64'd0);
        check_val("br_req", {63'd0, bus.imem_req}, 64'd1);
        check_val("br_addr", bus.imem_addr, 64'h8000_1000);

        // All three redirects together, coinciding with rvalid
        tick();
        ex = 1'b1; ex_ret = 1'b1; br_taken = 1'b1;
        ex_entry = 64'h8000_0100; epc = 64'h8000_0200; br_target = 64'h8000_0300;
        tick();
        ex = 1'b0; ex_ret = 1'b0; br_taken = 1'b0;
        check_val("prio_valid", {63'd0, bus.inst_valid}, 64'd0);
        check_val("prio_req", {63'd0, bus.imem_req}, 64'd1);
        check_val("prio_addr", bus.imem_addr, 64'h8000_0100);

        // Trap-return beats branch
        tick();
        ex_ret = 1'b1; br_taken = 1'b1;
        tick();
        ex_ret = 1'b0; br_taken = 1'b0;
        check_val("eret_addr", bus.imem_addr, 64'h8000_0200);
        tick();
        tick();
        check_val("eret_inst_pc", bus.inst_pc, 64'h8000_0200);
        check_val("eret_inst", {32'd0, bus.inst}, 64'h8000_0213);

        // Redirect in HOLD with id_ready=1 flushes; target at top of address space wraps
        br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        br_taken = 1'b0;
        check_val("hold_flush_valid", {63'd0, bus.inst_valid}, 64'd0);
        check_val("hold_flush_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        resp_en = 1'b0;
        tick();
        check_val("wrap_pc", pc, 64'd0);

        // Reset during WAIT, then a late response
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_req", {63'd0, bus.imem_req}, 64'd0);
        check_val("mid_rst_pc", pc, 64'h8000_0000);
        release_resp();
        tick();
        resp_en = 1'b1;
        check_val("late_rv_valid", {63'd0, bus.inst_valid}, 64'd0);
        check_val("late_rv_req", {63'd0, bus.imem_req}, 64'd1);
        check_val("late_rv_addr", bus.imem_addr, 64'h8000_0000);
        tick();
        tick();
        check_val("restart_valid", {63'd0, bus.inst_valid}, 64'd1);
        check_val("restart_inst", {32'd0, bus.inst}, 64'h8000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
